// File: rtl/cordic_pipe_sched.sv
// Round-robin issue of NREQ angle streams into one shared CORDIC core, with a {valid,id} tag line matching its latency.
// Latency LAT ce-cycles from grant to res_*; a held result (res_valid && !res_ready) freezes core, tags and grants.
module cordic_pipe_sched #(
   parameter int W    = 18,
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int LAT  = 21
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_angle,
   output logic [NREQ-1:0]   req_ready,
   output logic              pipe_ce,
   output logic [W-1:0]      pipe_angle,
   input  logic [W-1:0]      pipe_sin,
   input  logic [W-1:0]      pipe_cos,
   output logic              res_valid,
   output logic [IDW-1:0]    res_id,
   output logic [W-1:0]      res_sin,
   output logic [W-1:0]      res_cos,
   input  logic              res_ready,
   output logic [4:0]        inflight
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     gnt_idx;
   logic              gnt_vld;
   logic [PW:0]       cand;
   logic [2*NREQ-1:0] dbl_vld;
   logic [NREQ-1:0]   rot_vld;
   logic              retire;
   logic [LAT-1:0]    tag_vld;
   logic [IDW-1:0]    tag_id [LAT];

   // The core output register lines up with the last tag stage, so data passes straight through.
   assign res_valid = tag_vld[LAT-1];
   assign res_id    = tag_id[LAT-1];
   assign res_sin   = pipe_sin;
   assign res_cos   = pipe_cos;
   assign pipe_ce   = !(res_valid && !res_ready);
   assign retire    = res_valid && res_ready;

   // Rotate so that bit k of rot_vld is requester (rr_ptr + k) mod NREQ.
   assign dbl_vld = {req_valid, req_valid};
   assign rot_vld = NREQ'(dbl_vld >> rr_ptr);

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      if (pipe_ce && !reset) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!gnt_vld && rot_vld[k]) begin
               gnt_vld = 1'b1;
               cand    = {1'b0, rr_ptr} + (PW+1)'(k);
               if (cand >= (PW+1)'(NREQ))
                  cand = cand - (PW+1)'(NREQ);
               gnt_idx = cand[PW-1:0];
            end
         end
      end
   end

   always_comb begin
      req_ready  = '0;
      pipe_angle = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_vld && gnt_idx == PW'(i)) begin
            req_ready[i] = 1'b1;
            pipe_angle   = req_angle[i*W +: W];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr   <= '0;
         tag_vld  <= '0;
         inflight <= '0;
         for (int i = 0; i < LAT; i++)
            tag_id[i] <= '0;
      end else begin
         if (pipe_ce) begin
            tag_vld   <= {tag_vld[LAT-2:0], gnt_vld};
            tag_id[0] <= gnt_vld ? IDW'(gnt_idx) : '0;
            for (int i = 1; i < LAT; i++)
               tag_id[i] <= tag_id[i-1];
         end
         if (gnt_vld)
            rr_ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
         case ({gnt_vld, retire})
            2'b10:   inflight <= inflight + 5'd1;
            2'b01:   inflight <= inflight - 5'd1;
            default: inflight <= inflight;
         endcase
      end
   end

endmodule
